argmax_classifier: RTL and testbench

Final classification stage that consumes the dense layer's OUT_DIM-wide logit vector and produces the winning class index. On `start` it snapshots the vector, then sequentially scans it one element per cycle. It tracks the maximum and second-maximum logits, and reports index, maximum value, top-2 margin and a low-confidence flag. It pulses `done` on completion. Sits directly downstream of the fully-connected layer; its `start` is driven by that layer's `done`.

---
 rtl/argmax_classifier.sv | 166 ++++++++++++++++
 tb/tb_argmax_classifier.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/argmax_classifier.sv
// argmax_classifier
//   Final classification stage behind the dense layer. An accepted start
//   snapshots the logit vector. The block then scans one element per cycle
//   and tracks the best and second-best logits. It reports the winning
//   index, the maximum value, the top-2 margin and a low-confidence flag,
//   and pulses done when these results are updated.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   start        single-cycle request, honoured only while idle
//   in_vec       IN_DIM signed logits, sampled on an accepted start
//   class_idx    index of the maximum logit (lowest index wins ties)
//   max_val      signed maximum logit
//   margin       unsigned max - second max, DATA_WIDTH+1 bits
//   low_conf     margin < MARGIN_THRESH
//   busy         high while scanning or finishing
//   result_valid results valid, held until the next accepted start
//   done         one-cycle pulse when results are updated
module argmax_classifier #(
  parameter int DATA_WIDTH    = 16,
  parameter int IN_DIM        = 10,
  parameter int IDX_W         = $clog2(IN_DIM),
  parameter int MARGIN_THRESH = 128
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] in_vec [IN_DIM],
  output logic        [IDX_W-1:0]      class_idx,
  output logic signed [DATA_WIDTH-1:0] max_val,
  output logic        [DATA_WIDTH:0]   margin,
  output logic                         low_conf,
  output logic                         busy,
  output logic                         result_valid,
  output logic                         done
);

  if (IN_DIM < 2) begin : g_bad_dim
    $error("argmax_classifier: IN_DIM must be at least 2");
  end

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic signed [DATA_WIDTH-1:0] MIN_VAL  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic        [IDX_W-1:0]      LAST_IDX = IDX_W'(IN_DIM - 1);
  localparam logic        [DATA_WIDTH:0]   THRESH   = (DATA_WIDTH+1)'(MARGIN_THRESH);

  logic [1:0]                  state_q, state_d;
  logic signed [DATA_WIDTH-1:0] x_q [IN_DIM];
  logic signed [DATA_WIDTH-1:0] x_d [IN_DIM];
  logic signed [DATA_WIDTH-1:0] best_q, best_d;
  logic signed [DATA_WIDTH-1:0] second_q, second_d;
  logic [IDX_W-1:0]             best_idx_q, best_idx_d;
  logic [IDX_W-1:0]             i_q, i_d;
  logic [IDX_W-1:0]             class_idx_q, class_idx_d;
  logic signed [DATA_WIDTH-1:0] max_val_q, max_val_d;
  logic [DATA_WIDTH:0]          margin_q, margin_d;
  logic                         low_conf_q, low_conf_d;
  logic                         result_valid_q, result_valid_d;
  logic                         done_q, done_d;

  logic signed [DATA_WIDTH-1:0] elem;
  logic [DATA_WIDTH:0]          diff;

  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    best_d         = best_q;
    second_d       = second_q;
    best_idx_d     = best_idx_q;
    i_d            = i_q;
    class_idx_d    = class_idx_q;
    max_val_d      = max_val_q;
    margin_d       = margin_q;
    low_conf_d     = low_conf_q;
    result_valid_d = result_valid_q;
    done_d         = 1'b0;

    elem = x_q[i_q];
    // Sign-extend both operands by one bit; since best >= second the
    // modular difference is the exact non-negative margin.
    diff = {best_q[DATA_WIDTH-1], best_q} - {second_q[DATA_WIDTH-1], second_q};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d            = in_vec;
          best_d         = in_vec[0];
          best_idx_d     = '0;
          second_d       = MIN_VAL;
          i_d            = IDX_W'(1);
          result_valid_d = 1'b0;
          state_d        = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // Strict compares keep the earliest maximum; a duplicate of it
        // falls through into second.
        if (elem > best_q) begin
          second_d   = best_q;
          best_d     = elem;
          best_idx_d = i_q;
        end else if (elem > second_q) begin
          second_d = elem;
        end
        if (i_q == LAST_IDX) begin
          state_d = ST_FINISH;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      ST_FINISH: begin
        class_idx_d    = best_idx_q;
        max_val_d      = best_q;
        margin_d       = diff;
        low_conf_d     = (diff < THRESH);
        done_d         = 1'b1;
        result_valid_d = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      x_q            <= '{default: '0};
      best_q         <= '0;
      second_q       <= '0;
      best_idx_q     <= '0;
      i_q            <= '0;
      class_idx_q    <= '0;
      max_val_q      <= '0;
      margin_q       <= '0;
      low_conf_q     <= 1'b0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      best_q         <= best_d;
      second_q       <= second_d;
      best_idx_q     <= best_idx_d;
      i_q            <= i_d;
      class_idx_q    <= class_idx_d;
      max_val_q      <= max_val_d;
      margin_q       <= margin_d;
      low_conf_q     <= low_conf_d;
      result_valid_q <= result_valid_d;
      done_q         <= done_d;
    end
  end

  assign class_idx    = class_idx_q;
  assign max_val      = max_val_q;
  assign margin       = margin_q;
  assign low_conf     = low_conf_q;
  assign busy         = (state_q != ST_IDLE);
  assign result_valid = result_valid_q;
  assign done         = done_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Testbench for argmax_classifier: directed logit vectors with hand-computed
// results, plus a transaction-level reference that is compared every cycle.
module tb_argmax_classifier;

  localparam int DW = 16;
  localparam int N  = 10;
  localparam int IW = 4;
  localparam int TH = 128;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic signed [DW-1:0] in_vec [N];
  logic [IW-1:0]        class_idx;
  logic signed [DW-1:0] max_val;
  logic [DW:0]          margin;
  logic                 low_conf, busy, result_valid, done;

  argmax_classifier #(
    .DATA_WIDTH(DW),
    .IN_DIM(N),
    .IDX_W(IW),
    .MARGIN_THRESH(TH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .in_vec(in_vec),
    .class_idx(class_idx),
    .max_val(max_val),
    .margin(margin),
    .low_conf(low_conf),
    .busy(busy),
    .result_valid(result_valid),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a request is a snapshot plus a countdown of IN_DIM edges.
  // The result is the first index holding the maximum. The runner-up is the
  // largest value at any other index.
  int                   rem;
  int                   m_bi, m_sv;
  logic signed [DW-1:0] snap [N];
  logic [IW-1:0]        e_idx;
  logic signed [DW-1:0] e_max;
  logic [DW:0]          e_margin;
  logic                 e_lc, e_valid, e_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rem = 0; e_idx = '0; e_max = '0; e_margin = '0;
      e_lc = 1'b0; e_valid = 1'b0; e_done = 1'b0;
    end else begin
      e_done = 1'b0;
      if (rem == 0) begin
        if (start) begin
          for (int i = 0; i < N; i++) snap[i] = in_vec[i];
          rem = N;
          e_valid = 1'b0;
        end
      end else begin
        rem = rem - 1;
        if (rem == 0) begin
          m_bi = 0;
          for (int i = 1; i < N; i++) if (snap[i] > snap[m_bi]) m_bi = i;
          m_sv = -(1 << (DW - 1));
          for (int i = 0; i < N; i++)
            if (i != m_bi && int'(snap[i]) > m_sv) m_sv = int'(snap[i]);
          e_idx    = IW'(m_bi);
          e_max    = snap[m_bi];
          e_margin = (DW+1)'(int'(snap[m_bi]) - m_sv);
          e_lc     = (int'(snap[m_bi]) - m_sv) < TH;
          e_done   = 1'b1;
          e_valid  = 1'b1;
        end
      end
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_class_idx", 32'(class_idx), 32'(e_idx));
      chk("cyc_max_val", 32'(max_val), 32'(e_max));
      chk("cyc_margin", 32'(margin), 32'(e_margin));
      chk("cyc_low_conf", 32'(low_conf), 32'(e_lc));
      chk("cyc_busy", 32'(busy), 32'(rem != 0));
      chk("cyc_result_valid", 32'(result_valid), 32'(e_valid));
      chk("cyc_done", 32'(done), 32'(e_done));
    end
  end

  int v_peak [N] = '{3, -5, 100, 7, 0, 2, -1, 99, 4, 8};
  int v_tie  [N] = '{10, 50, 50, 0, 0, 0, 0, 0, 0, 0};
  int v_last [N] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 900};
  int v_ext  [N] = '{-32768, -32768, -32768, -32768, 32767, -32768, -32768, -32768, -32768, -32768};
  int v_min  [N] = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
  int v_t128 [N] = '{128, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int v_t127 [N] = '{-3, -3, -3, -3, -3, -3, -3, 124, -3, -3};
  int v_dist [N] = '{30000, 30000, 30000, 30000, 30000, 30000, 30000, 30000, 30000, 30000};

  task automatic set_vec(input int v [N]);
    for (int i = 0; i < N; i++) in_vec[i] = DW'(v[i]);
  endtask

  // Issue one request and wait (bounded) for done. b2b issues start right
  // after the previous done; disturb re-pulses start with a different vector
  // in the middle of the scan.
  task automatic run(input string nm, input int v [N], input bit b2b, input bit disturb,
                     input int x_idx, input int x_max, input int x_margin, input int x_lc);
    int cyc;
    if (!b2b) @(posedge clk);
    #2;
    set_vec(v);
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 30) begin
      @(posedge clk);
      cyc++;
      #1;
      if (disturb && cyc == 3) begin set_vec(v_dist); start = 1'b1; end
      if (disturb && cyc == 4) start = 1'b0;
    end
    chk({nm, "_latency"}, 32'(cyc), 32'(N));
    chk({nm, "_class_idx"}, 32'(class_idx), 32'(x_idx));
    chk({nm, "_max_val"}, 32'(max_val), 32'(x_max));
    chk({nm, "_margin"}, 32'(margin), 32'(x_margin));
    chk({nm, "_low_conf"}, 32'(low_conf), 32'(x_lc));
    chk({nm, "_result_valid"}, 32'(result_valid), 32'd1);
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    start = 1'b0;
    set_vec(v_min);
    #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_class_idx", 32'(class_idx), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    run("peak", v_peak, 1'b0, 1'b0, 2, 100, 1, 1);
    run("tie", v_tie, 1'b0, 1'b0, 1, 50, 0, 1);
    run("last", v_last, 1'b0, 1'b0, 9, 900, 900, 0);
    run("extreme", v_ext, 1'b0, 1'b0, 4, 32767, 65535, 0);
    run("allmin", v_min, 1'b0, 1'b0, 0, -32768, 0, 1);
    run("thr128", v_t128, 1'b0, 1'b0, 0, 128, 128, 0);
    run("thr127", v_t127, 1'b0, 1'b0, 7, 124, 127, 1);
    run("busy", v_peak, 1'b0, 1'b1, 2, 100, 1, 1);

    // Abort a scan with an asynchronous reset in its fifth cycle.
    @(posedge clk);
    #2 set_vec(v_last); start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("abort_class_idx", 32'(class_idx), 32'd0);
    chk("abort_max_val", 32'(max_val), 32'd0);
    chk("abort_margin", 32'(margin), 32'd0);
    chk("abort_low_conf", 32'(low_conf), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result_valid", 32'(result_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1 if (done === 1'b1) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    run("fresh", v_tie, 1'b0, 1'b0, 1, 50, 0, 1);
    run("b2b_a", v_ext, 1'b0, 1'b0, 4, 32767, 65535, 0);
    run("b2b_b", v_peak, 1'b1, 1'b0, 2, 100, 1, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("hold_class_idx", 32'(class_idx), 32'd2);
    chk("hold_result_valid", 32'(result_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
